// File: rtl/bfloat_mul_seq_if.sv
// rtl/bfloat_mul_seq_if.sv - operand/result handshake bundle for bfloat_mul_seq
interface bfloat_mul_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W-1:0] flp_a;
  logic [EXP_W+MAN_W-1:0] flp_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W-1:0] result;
  logic [2:0]             flags;

  modport master (
    output in_valid, flp_a, flp_b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, flp_a, flp_b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/bfloat_mul_seq.sv
// rtl/bfloat_mul_seq.sv - multi-cycle shift-add unsigned float multiplier
// Round-to-nearest-even when BFLOAT_MUL_RNE_EN is defined, truncation otherwise.
module bfloat_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  bfloat_mul_seq_if.slave  mul_if
);
  localparam int W  = EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(SW + 1);
  localparam logic [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
`ifdef BFLOAT_MUL_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t             state_q;
  logic [EXP_W-1:0]   exp_a_q, exp_b_q;
  logic [PW-1:0]      mcand_q;
  logic [SW-1:0]      mplier_q;
  logic [PW-1:0]      acc_q;
  logic [CW-1:0]      cnt_q;
  logic [W-1:0]       result_q;
  logic [2:0]         flags_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic               shift;
  logic [PW-2:0]      pn;
  logic [MAN_W-1:0]   frac;
  logic               guard, sticky, round_up;
  logic [MAN_W:0]     frac_r;
  logic [EW-1:0]      e;
  logic               a_zero, b_zero, a_inf, b_inf;
  logic [W-1:0]       result_d;
  logic [2:0]         flags_d;

  // Product is in [1,4): pn drops the hidden one so only fraction bits remain.
  always_comb begin
    shift    = acc_q[PW-1];
    pn       = shift ? acc_q[PW-2:0] : {acc_q[PW-3:0], 1'b0};
    frac     = pn[PW-2 -: MAN_W];
    guard    = pn[PW-2-MAN_W];
    sticky   = |pn[PW-3-MAN_W:0];
    round_up = RNE_EN & guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    e        = {2'b00, exp_a_q} + {2'b00, exp_b_q} - BIAS
             + {{(EW-1){1'b0}}, shift} + {{(EW-1){1'b0}}, frac_r[MAN_W]};
    a_zero   = (exp_a_q == '0);
    b_zero   = (exp_b_q == '0);
    a_inf    = &exp_a_q;
    b_inf    = &exp_b_q;
    result_d = {e[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flags_d  = 3'b000;
    if ((a_zero && b_inf) || (a_inf && b_zero)) begin
      result_d = '1;
      flags_d  = 3'b100;
    end else if (a_zero || b_zero) begin
      result_d = '0;
    end else if (a_inf || b_inf) begin
      result_d = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (!e[EW-1] && (e >= EMAX)) begin
      result_d = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d  = 3'b010;
    end else if (e[EW-1] || (e == '0)) begin
      result_d = '0;
      flags_d  = 3'b001;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_if.in_valid) begin
            exp_a_q    <= mul_if.flp_a[W-1 -: EXP_W];
            exp_b_q    <= mul_if.flp_b[W-1 -: EXP_W];
            mcand_q    <= {{SW{1'b0}}, 1'b1, mul_if.flp_a[MAN_W-1:0]};
            mplier_q   <= {1'b1, mul_if.flp_b[MAN_W-1:0]};
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_MUL;
          end
        end
        S_MUL: begin
          // Special cases still run the full loop so latency is constant.
          acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= {mcand_q[PW-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[SW-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(MAN_W)) begin
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          result_q    <= result_d;
          flags_q     <= flags_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (mul_if.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul_if.in_ready  = in_ready_q;
  assign mul_if.out_valid = out_valid_q;
  assign mul_if.result    = result_q;
  assign mul_if.flags     = flags_q;
endmodule

// File: tb/tb_bfloat_mul_seq.sv
// tb/tb_bfloat_mul_seq.sv - self-checking bench for bfloat_mul_seq
module tb_bfloat_mul_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int W     = EXP_W + MAN_W;
  localparam int LAT   = MAN_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bfloat_mul_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
  bfloat_mul_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .mul_if (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer significand product, remainder-vs-half rounding.
  function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [2:0] f);
    int ea, eb, p, e, drop, fr, rem, half, emax;
    emax = (1 << EXP_W) - 1;
    ea = int'(a[W-1 -: EXP_W]);
    eb = int'(b[W-1 -: EXP_W]);
    f  = 3'b000;
    if ((ea == 0 && eb == emax) || (ea == emax && eb == 0)) begin
      r = '1; f = 3'b100; return;
    end
    if (ea == 0 || eb == 0) begin r = '0; return; end
    if (ea == emax || eb == emax) begin r = W'(emax << MAN_W); return; end
    p = ((1 << MAN_W) + int'(a[MAN_W-1:0])) * ((1 << MAN_W) + int'(b[MAN_W-1:0]));
    e = ea + eb - ((1 << (EXP_W - 1)) - 1);
    drop = MAN_W;
    if (p >= (1 << (2 * MAN_W + 1))) begin
      e++;
      drop = MAN_W + 1;
    end
    fr   = (p >> drop) - (1 << MAN_W);
    rem  = p & ((1 << drop) - 1);
    half = 1 << (drop - 1);
`ifdef BFLOAT_MUL_RNE_EN
    if (rem > half || (rem == half && (fr % 2) == 1)) fr++;
`endif
    if (fr == (1 << MAN_W)) begin fr = 0; e++; end
    if (e >= emax) begin
      r = W'(emax << MAN_W); f = 3'b010;
    end else if (e <= 0) begin
      r = '0; f = 3'b001;
    end else begin
      r = W'((e << MAN_W) | fr);
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [2:0] ef,
                       input string tag, input bit hold, input bit tie);
    int lat;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.flp_a    = a;
    bus.flp_b    = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_result"}, 32'(bus.result), 32'(er));
    chk({tag, "_flags"}, 32'(bus.flags), 32'(ef));
    if (!hold) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = tie;
      chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] a, b, r;
    logic [2:0]   f;
    logic [W-1:0] rne_exp;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flp_a     = '0;
    bus.flp_b     = '0;
    rst           = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef BFLOAT_MUL_RNE_EN
    rne_exp = 15'h3FC3;
`else
    rne_exp = 15'h3FC2;
`endif
    do_op(15'h3FC0, 15'h3FC0, 15'h4010, 3'b000, "mul_1p5_1p5", 1'b0, 1'b0);
    do_op(15'h3FC0, 15'h4000, 15'h4040, 3'b000, "mul_1p5_2", 1'b0, 1'b0);
    do_op(15'h3FC1, 15'h3F81, rne_exp, 3'b000, "round", 1'b0, 1'b0);
    do_op(15'h0080, 15'h0080, 15'h0000, 3'b001, "underflow", 1'b0, 1'b0);
    do_op(15'h0000, 15'h7F80, 15'h7FFF, 3'b100, "zero_x_inf", 1'b0, 1'b0);

    // Overflow result held under backpressure while stray in_valid pulses arrive.
    do_op(15'h7F00, 15'h4000, 15'h7F80, 3'b010, "overflow", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.flp_a    = W'($urandom);
      bus.flp_b    = W'($urandom);
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", 32'(bus.result), 32'h7F80);
      chk("bp_flags", 32'(bus.flags), 32'd2);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset in the fourth MUL cycle.
    bus.in_valid = 1'b1;
    bus.flp_a    = 15'h3FC0;
    bus.flp_b    = 15'h3FC0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_flags", 32'(bus.flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(15'h3F80, 15'h3F80, 15'h3F80, 3'b000, "post_reset", 1'b0, 1'b0);

    // Back-to-back random traffic with out_ready tied high.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) != 0) a[W-1 -: EXP_W] = EXP_W'($urandom_range(100, 154));
      if ($urandom_range(0, 7) != 0) b[W-1 -: EXP_W] = EXP_W'($urandom_range(100, 154));
      ref_mul(a, b, r, f);
      do_op(a, b, r, f, "random", 1'b0, 1'b1);
    end
    bus.out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
